// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush sequencer for the 5-stage RV32 pipeline.
// Combines load-use, taken-branch, data-memory wait and multi-cycle MDU
// conditions into per-stage write-enables and bubble flushes (zero latency).
module hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read_en,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mdu_op,
  input  logic             branch_taken_in,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             mdu_done,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             mem_wb_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_start,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned      WC_W      = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic            done_seen, done_seen_n;
  logic [WC_W-1:0] wait_cnt, wait_cnt_n;
  logic            err, err_n;

  logic mem_stall;
  logic load_use;
  logic done_eff;
  logic timeout;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read_en & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign done_eff  = mdu_done | done_seen;
  assign timeout   = (wait_cnt == WAIT_LAST) & ~done_eff;

  assign mdu_timeout_err = err;

  // Next-state and stage control decode; defaults let the pipeline flow.
  always_comb begin
    state_n         = state;
    done_seen_n     = done_seen;
    wait_cnt_n      = wait_cnt;
    err_n           = err;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    mdu_start       = 1'b0;

    if (rst) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            // Whole pipe frozen; an MDU launch waits until memory completes.
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_write_en = 1'b0;
          end else if (ex_mdu_op) begin
            mdu_start      = 1'b1;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            ex_mem_flush   = 1'b1;
            state_n        = MDU_WAIT;
            wait_cnt_n     = '0;
            done_seen_n    = 1'b0;
          end else if (branch_taken_in) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
          end
        end
        MDU_WAIT: begin
          // Counter holds at the limit so a timeout seen under mem_stall persists.
          if (wait_cnt != WAIT_LAST) begin
            wait_cnt_n = wait_cnt + WC_W'(1);
          end
          done_seen_n = done_eff;
          if (mem_stall) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_write_en = 1'b0;
          end else if (done_eff | timeout) begin
            state_n     = RUN;
            done_seen_n = 1'b0;
            wait_cnt_n  = '0;
            if (timeout) begin
              err_n = 1'b1;
            end
          end else begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            ex_mem_flush   = 1'b1;
          end
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  // State, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      done_seen    <= 1'b0;
      wait_cnt     <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_n;
      done_seen <= done_seen_n;
      wait_cnt  <= wait_cnt_n;
      err       <= err_n;
      if (!pc_write_en && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the hazard sequencing rules.
module tb_hazard_ctrl;

  localparam int unsigned MDU_TIMEOUT = 64;
  localparam int unsigned CNT_W       = 32;

  // Expected stage control patterns:
  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_fl, id_ex_fl, ex_mem_fl, mdu_start}
  localparam logic [8:0] P_DEF    = 9'b11111_000_0;
  localparam logic [8:0] P_FREEZE = 9'b00000_000_0;
  localparam logic [8:0] P_LAUNCH = 9'b00011_001_1;
  localparam logic [8:0] P_HOLD   = 9'b00011_001_0;
  localparam logic [8:0] P_BRANCH = 9'b11111_110_0;
  localparam logic [8:0] P_LU     = 9'b00111_010_0;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mdu;
    logic       br;
    logic       req;
    logic       rdy;
    logic       done;
  } stim_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             ex_mem_read_en = 1'b0, ex_mdu_op = 1'b0, branch_taken_in = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0, mdu_done = 1'b0;
  logic             pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, mdu_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed / expected for the most recent applied cycle.
  logic [8:0]       obs_o, exp_o;
  logic             obs_err, exp_err;
  logic [CNT_W-1:0] obs_stall, exp_stall;

  // Reference model state.
  bit     m_in_mdu = 1'b0;
  int     m_waited = 0;
  bit     m_done   = 1'b0;
  bit     m_err    = 1'b0;
  longint m_stall  = 0;

  stim_t s;

  hazard_ctrl #(.MDU_TIMEOUT(MDU_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read_en(ex_mem_read_en), .ex_rd(ex_rd), .ex_mdu_op(ex_mdu_op),
    .branch_taken_in(branch_taken_in), .mem_req(mem_req), .mem_ready(mem_ready),
    .mdu_done(mdu_done),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .mem_wb_write_en(mem_wb_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mdu_start(mdu_start), .mdu_timeout_err(mdu_timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, capture DUT outputs before the edge, advance model.
  task automatic apply(input stim_t st);
    logic [8:0] e;
    bit ms, lu, done_now, expired;
    @(negedge clk);
    rst = st.rst; ex_mem_read_en = st.ld; ex_rd = st.rd; id_rs1 = st.rs1; id_rs2 = st.rs2;
    ex_mdu_op = st.mdu; branch_taken_in = st.br; mem_req = st.req; mem_ready = st.rdy;
    mdu_done = st.done;
    #2;
    obs_o     = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mdu_start};
    obs_err   = mdu_timeout_err;
    obs_stall = stall_cycles;
    exp_err   = m_err;
    exp_stall = CNT_W'(m_stall);
    if (st.rst) begin
      e = P_FREEZE;
      m_in_mdu = 1'b0; m_waited = 0; m_done = 1'b0; m_err = 1'b0; m_stall = 0;
    end else begin
      ms = st.req && !st.rdy;
      lu = st.ld && (st.rd != 5'd0) && (st.rd == st.rs1 || st.rd == st.rs2);
      e  = P_DEF;
      if (!m_in_mdu) begin
        if (ms) e = P_FREEZE;
        else if (st.mdu) begin
          e = P_LAUNCH; m_in_mdu = 1'b1; m_waited = 0; m_done = 1'b0;
        end
        else if (st.br) e = P_BRANCH;
        else if (lu) e = P_LU;
      end else begin
        done_now = st.done || m_done;
        expired  = (m_waited >= int'(MDU_TIMEOUT) - 1) && !done_now;
        if (ms) begin
          e = P_FREEZE; m_done = done_now; m_waited++;
        end else if (done_now || expired) begin
          e = P_DEF; m_in_mdu = 1'b0; m_waited = 0; m_done = 1'b0;
          if (expired) m_err = 1'b1;
        end else begin
          e = P_HOLD; m_waited++;
        end
      end
      if (!e[8] && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
    end
    exp_o = e;
  endtask

  task automatic do_reset();
    s = '0; s.rst = 1'b1; apply(s); s = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (obs_o !== P_FREEZE) begin n_bad++; $display("FAIL reset_outputs got=%b want=%b", obs_o, P_FREEZE); end
    s = '0; apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL reset_idle got=%b want=%b", obs_o, P_DEF); end
    n_cmp++; if (obs_stall !== 32'd0) begin n_bad++; $display("FAIL reset_stall got=%0d want=0", obs_stall); end
    n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", obs_err); end
  endtask

  task automatic test_load_use();
    do_reset();
    s = '0; s.ld = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs2 = 5'd9; apply(s);
    n_cmp++; if (obs_o !== P_LU) begin n_bad++; $display("FAIL lu_stall got=%b want=%b", obs_o, P_LU); end
    s.rd = 5'd0; s.rs1 = 5'd0; apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL lu_x0 got=%b want=%b", obs_o, P_DEF); end
    n_cmp++; if (obs_stall !== 32'd1) begin n_bad++; $display("FAIL lu_count got=%0d want=1", obs_stall); end
    s = '0; apply(s);
    n_cmp++; if (obs_stall !== 32'd1) begin n_bad++; $display("FAIL lu_x0_count got=%0d want=1", obs_stall); end
  endtask

  task automatic test_mdu();
    do_reset();
    s = '0; s.mdu = 1'b1; apply(s);
    n_cmp++; if (obs_o !== P_LAUNCH) begin n_bad++; $display("FAIL mdu_launch got=%b want=%b", obs_o, P_LAUNCH); end
    for (int c = 1; c <= 3; c++) begin
      apply(s);
      n_cmp++; if (obs_o !== P_HOLD) begin n_bad++; $display("FAIL mdu_hold c%0d got=%b want=%b", c, obs_o, P_HOLD); end
    end
    s.done = 1'b1; apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL mdu_release got=%b want=%b", obs_o, P_DEF); end
    // Load-use response proves the sequencer is back in RUN.
    s = '0; s.ld = 1'b1; s.rd = 5'd3; s.rs2 = 5'd3; apply(s);
    n_cmp++; if (obs_o !== P_LU) begin n_bad++; $display("FAIL mdu_back_run got=%b want=%b", obs_o, P_LU); end
    n_cmp++; if (obs_stall !== 32'd4) begin n_bad++; $display("FAIL mdu_count got=%0d want=4", obs_stall); end
  endtask

  task automatic test_branch();
    do_reset();
    s = '0; s.ld = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.br = 1'b1; apply(s);
    n_cmp++; if (obs_o !== P_BRANCH) begin n_bad++; $display("FAIL branch_over_lu got=%b want=%b", obs_o, P_BRANCH); end
    s = '0; apply(s);
    n_cmp++; if (obs_stall !== 32'd0) begin n_bad++; $display("FAIL branch_count got=%0d want=0", obs_stall); end
  endtask

  task automatic test_mem_stall_launch();
    do_reset();
    s = '0; s.mdu = 1'b1; s.req = 1'b1; s.rdy = 1'b0;
    for (int c = 0; c <= 2; c++) begin
      apply(s);
      n_cmp++; if (obs_o !== P_FREEZE) begin n_bad++; $display("FAIL memstall_defer c%0d got=%b want=%b", c, obs_o, P_FREEZE); end
    end
    s.req = 1'b0; apply(s);
    n_cmp++; if (obs_o !== P_LAUNCH) begin n_bad++; $display("FAIL memstall_launch got=%b want=%b", obs_o, P_LAUNCH); end
    s.done = 1'b1; apply(s);
    s = '0; apply(s);
    n_cmp++; if (obs_stall !== 32'd4) begin n_bad++; $display("FAIL memstall_count got=%0d want=4", obs_stall); end
  endtask

  task automatic test_done_in_stall();
    do_reset();
    s = '0; s.mdu = 1'b1; apply(s);
    s.req = 1'b1; s.rdy = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      s.done = (c == 2);
      apply(s);
      n_cmp++; if (obs_o !== P_FREEZE) begin n_bad++; $display("FAIL donestall_hold c%0d got=%b want=%b", c, obs_o, P_FREEZE); end
    end
    s.req = 1'b0; s.done = 1'b0; apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL donestall_release got=%b want=%b", obs_o, P_DEF); end
    s = '0; apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL donestall_no_relaunch got=%b want=%b", obs_o, P_DEF); end
  endtask

  task automatic test_timeout();
    do_reset();
    s = '0; s.mdu = 1'b1; apply(s);
    for (int c = 1; c <= 63; c++) begin
      apply(s);
      n_cmp++; if (obs_o !== P_HOLD) begin n_bad++; $display("FAIL timeout_hold c%0d got=%b want=%b", c, obs_o, P_HOLD); end
    end
    apply(s);
    n_cmp++; if (obs_o !== P_DEF) begin n_bad++; $display("FAIL timeout_release got=%b want=%b", obs_o, P_DEF); end
    n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_early got=%b want=0", obs_err); end
    s = '0; apply(s);
    n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%b want=1", obs_err); end
    n_cmp++; if (obs_stall !== 32'd64) begin n_bad++; $display("FAIL timeout_count got=%0d want=64", obs_stall); end
    // Reset in the middle of a wait, with a done arriving just before it.
    s.mdu = 1'b1; apply(s); apply(s);
    s.done = 1'b1; s.req = 1'b1; apply(s);
    do_reset();
    n_cmp++; if (obs_o !== P_FREEZE) begin n_bad++; $display("FAIL midrst_outputs got=%b want=%b", obs_o, P_FREEZE); end
    s = '0; s.ld = 1'b1; s.rd = 5'd1; s.rs1 = 5'd1; apply(s);
    n_cmp++; if (obs_o !== P_LU) begin n_bad++; $display("FAIL midrst_run got=%b want=%b", obs_o, P_LU); end
    n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b want=0", obs_err); end
    n_cmp++; if (obs_stall !== 32'd0) begin n_bad++; $display("FAIL midrst_count got=%0d want=0", obs_stall); end
  endtask

  task automatic test_random();
    int bad_o, bad_e, bad_s;
    int done_div;
    bad_o = 0; bad_e = 0; bad_s = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      done_div = (i < 2000) ? 8 : 120;
      s       = '0;
      s.rst   = ($urandom_range(0, 299) == 0);
      s.ld    = ($urandom_range(0, 1) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.mdu   = ($urandom_range(0, 5) == 0);
      s.br    = ($urandom_range(0, 4) == 0);
      s.req   = ($urandom_range(0, 2) == 0);
      s.rdy   = ($urandom_range(0, 1) == 0);
      s.done  = ($urandom_range(0, done_div - 1) == 0);
      apply(s);
      n_cmp++;
      if (obs_o !== exp_o) begin
        n_bad++; bad_o++;
        if (bad_o <= 5) $display("FAIL rand_ctrl cyc%0d got=%b want=%b", i, obs_o, exp_o);
      end
      n_cmp++;
      if (obs_err !== exp_err) begin
        n_bad++; bad_e++;
        if (bad_e <= 5) $display("FAIL rand_err cyc%0d got=%b want=%b", i, obs_err, exp_err);
      end
      n_cmp++;
      if (obs_stall !== exp_stall) begin
        n_bad++; bad_s++;
        if (bad_s <= 5) $display("FAIL rand_count cyc%0d got=%0d want=%0d", i, obs_stall, exp_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_branch();
    test_mem_stall_launch();
    test_done_in_stall();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
